// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared constants for the common data bus (CDB) arbiter and its producers.
//   DATA_LEN / ROB_LEN : result width and ROB index width (tag = ROB_LEN+1 bits)
//   ZERO_ROB / ZERO_WORD: "no tag" marker and all-zero result
//   CDB_REQ_NUM        : number of CDB producers
//   CDB_SRC_*          : producer index of ALU, load/store buffer, branch unit
//   rr_wrap()          : single-step modulo wrap used by the round-robin search
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

    localparam int DATA_LEN    = 32;
    localparam int ROB_LEN     = 4;
    localparam int TAG_LEN     = ROB_LEN + 1;
    localparam int CDB_REQ_NUM = 3;

    localparam logic [TAG_LEN-1:0]  ZERO_ROB  = 5'd0;
    localparam logic [DATA_LEN-1:0] ZERO_WORD = 32'h0000_0000;

    localparam int CDB_SRC_ALU = 0;
    localparam int CDB_SRC_LSB = 1;
    localparam int CDB_SRC_BR  = 2;

    // Wraps an index that is at most one full lap past n back into [0, n).
    function automatic int rr_wrap(input int idx, input int n);
        int r;
        if (idx >= n) begin
            r = idx - n;
        end else begin
            r = idx;
        end
        return r;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_if
// Bundles the producer handshake and the CDB broadcast bus.
//   valid_from_req / rob_id_from_req / result_from_req : producer offers (packed)
//   ready_to_req                                       : per-producer queue not full
//   valid_to_cdb / rob_id_to_cdb / result_to_cdb /
//   src_to_cdb                                         : registered CDB broadcast
// Modports: slave = the arbiter, master = producers plus CDB consumers.
// -----------------------------------------------------------------------------
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int REQ_NUM = CDB_REQ_NUM,
    parameter int DATA_W  = DATA_LEN,
    parameter int TAG_W   = ROB_LEN + 1
) ();

    localparam int SRC_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    logic [REQ_NUM-1:0]        valid_from_req;
    logic [REQ_NUM*TAG_W-1:0]  rob_id_from_req;
    logic [REQ_NUM*DATA_W-1:0] result_from_req;
    logic [REQ_NUM-1:0]        ready_to_req;
    logic                      valid_to_cdb;
    logic [TAG_W-1:0]          rob_id_to_cdb;
    logic [DATA_W-1:0]         result_to_cdb;
    logic [SRC_W-1:0]          src_to_cdb;

    modport slave (
        input  valid_from_req, rob_id_from_req, result_from_req,
        output ready_to_req, valid_to_cdb, rob_id_to_cdb, result_to_cdb, src_to_cdb
    );

    modport master (
        output valid_from_req, rob_id_from_req, result_from_req,
        input  ready_to_req, valid_to_cdb, rob_id_to_cdb, result_to_cdb, src_to_cdb
    );

endinterface

// File: rtl/cdb_req_fifo.sv
// -----------------------------------------------------------------------------
// cdb_req_fifo
// Small synchronous FIFO holding one producer's pending {tag, result} entries.
//   clk, rst    : clock, synchronous active-high reset
//   flush_i     : empties the FIFO (counts and pointers to 0), beats push/pop
//   push_i      : write din_i (ignored when full)
//   pop_i       : drop the head entry (ignored when empty)
//   full_o      : count == DEPTH, decoded from the registered count only
//   empty_o     : count == 0
//   head_o      : oldest entry
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module cdb_req_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty_o   = (cnt_q == (PTR_W+1)'(0));
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;
    assign head_o    = mem_q[rd_ptr_q];

    // Pointer and occupancy next state; flush clears everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
                2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage; cleared on reset so the head never presents unknowns.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push_s && !flush_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Shares the single common data bus between REQ_NUM producers (0 = ALU,
// 1 = load/store buffer, 2 = branch unit). Each producer feeds a private
// cdb_req_fifo; one head per cycle is granted onto a registered CDB.
//   clk, rst : clock, synchronous active-high reset
//   flush    : rollback; empties all queues, kills the broadcast, discards
//              same-cycle offers, keeps the round-robin pointer
//   bus      : cdb_arbiter_if.slave (producer handshake + CDB outputs)
// Configuration macro CDB_RR_ARB_EN: defined -> round-robin grant;
// undefined -> fixed priority, lowest index wins, no pointer register.
// -----------------------------------------------------------------------------
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int REQ_NUM     = CDB_REQ_NUM,
    parameter int QUEUE_DEPTH = 2,
    parameter int DATA_W      = DATA_LEN,
    parameter int TAG_W       = ROB_LEN + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    cdb_arbiter_if.slave bus
);

    localparam int SRC_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam int ENT_W = TAG_W + DATA_W;

    logic [REQ_NUM-1:0] push_s, pop_s, full_s, empty_s;
    logic [ENT_W-1:0]   head_s [REQ_NUM];
    logic [ENT_W-1:0]   head_sel_s;
    logic [SRC_W:0]     pick_s;
    logic               grant_vld_s;
    logic [SRC_W-1:0]   grant_idx_s;

    logic               valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic [SRC_W-1:0]   src_q, src_d;

    // First set bit of cand searching upward from start with wrap; MSB = found.
    function automatic logic [SRC_W:0] pick_first(input logic [REQ_NUM-1:0] cand,
                                                  input int start);
        logic [SRC_W:0]     sel;
        logic [REQ_NUM-1:0] rot;
        int                 c;
        sel = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            c   = rr_wrap(start + k, REQ_NUM);
            rot = cand >> c;
            if (!sel[SRC_W] && rot[0]) begin
                sel = {1'b1, SRC_W'(c)};
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

    for (genvar i = 0; i < REQ_NUM; i++) begin : g_req
        logic [TAG_W-1:0]  tag_s;
        logic [DATA_W-1:0] res_s;

        assign tag_s = bus.rob_id_from_req[i*TAG_W +: TAG_W];
        assign res_s = bus.result_from_req[i*DATA_W +: DATA_W];
        // Tag 0 carries no result: accept the handshake but never queue it.
        assign push_s[i] = bus.valid_from_req[i] & ~full_s[i] & (tag_s != TAG_W'(ZERO_ROB));
        assign pop_s[i]  = grant_vld_s & (grant_idx_s == SRC_W'(i)) & ~flush;

        cdb_req_fifo #(
            .DEPTH (QUEUE_DEPTH),
            .WIDTH (ENT_W)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .flush_i (flush),
            .push_i  (push_s[i]),
            .pop_i   (pop_s[i]),
            .din_i   ({tag_s, res_s}),
            .full_o  (full_s[i]),
            .empty_o (empty_s[i]),
            .head_o  (head_s[i])
        );
    end

    // No full bypass: a pop in the same cycle does not raise ready.
    assign bus.ready_to_req = ~full_s;

`ifdef CDB_RR_ARB_EN
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;

    assign pick_s = pick_first(~empty_s, int'(rr_ptr_q));

    // Pointer moves past the winner; it is kept across flush and idle cycles.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_vld_s && !flush) begin
            rr_ptr_d = SRC_W'(rr_wrap(int'(grant_idx_s) + 1, REQ_NUM));
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    assign pick_s = pick_first(~empty_s, 32'sd0);
`endif

    assign grant_vld_s = pick_s[SRC_W];
    assign grant_idx_s = pick_s[SRC_W-1:0];
    assign head_sel_s  = head_s[grant_idx_s];

    // Broadcast next state; tag/result/source hold when nothing is granted.
    always_comb begin
        valid_d  = 1'b0;
        tag_d    = tag_q;
        result_d = result_q;
        src_d    = src_q;
        if (grant_vld_s && !flush) begin
            valid_d  = 1'b1;
            tag_d    = head_sel_s[ENT_W-1 -: TAG_W];
            result_d = head_sel_s[DATA_W-1:0];
            src_d    = grant_idx_s;
        end else begin
            valid_d  = 1'b0;
        end
    end

    // CDB output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            tag_q    <= TAG_W'(ZERO_ROB);
            result_q <= DATA_W'(ZERO_WORD);
            src_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            result_q <= result_d;
            src_q    <= src_d;
        end
    end

    assign bus.valid_to_cdb  = valid_q;
    assign bus.rob_id_to_cdb = tag_q;
    assign bus.result_to_cdb = result_q;
    assign bus.src_to_cdb    = src_q;

endmodule
